muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer for the RV32M extension, instantiated in the execute stage. It accepts one M-type operation per request, runs 32 one-bit iterations (shift-add for multiply, restoring for divide) and returns one 32-bit result. It drives the execute-stage stall request while an operation is in flight. The pipeline's flush kills an in-flight operation.

## Interface

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per non-trivial operation; equals XLEN.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  request; an M-type instruction is present in execute.
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i  in  32  operand 1 (multiplicand/dividend).
- rs2_i  in  32  operand 2 (multiplier/divisor).
- flush_i  in  1  kill the current operation (jump/branch taken).
- busy_o  out  1  state is CALC.
- done_o  out  1  one-cycle pulse; result_o is valid in this cycle.
- result_o  out  32  result, registered.
- stallreq_o  out  1  stall request to pipeline control.

## Operation

States:
- IDLE
- CALC (counter 0..31)
- DONE

Transitions from IDLE:
- start_i=1, flush_i=0, normal case: latch |rs1|, |rs2| (per signedness), op_i and result sign; clear accumulator and counter; go to CALC.
- start_i=1, flush_i=0, fast case: load result_o directly and go to DONE.
  - DIV/DIVU by zero: quotient 0xFFFFFFFF.
  - REM/REMU by zero: remainder = rs1_i.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF: remainder 0.

Transitions from CALC:
- One iteration per cycle; counter increments.
- After iteration 31 completes, apply the sign correction, load result_o and go to DONE.

Transitions from DONE:
- Always go to IDLE. start_i is ignored in DONE.

Flush:
- flush_i=1 in any state forces IDLE on the next edge.
- done_o is not pulsed for the killed operation; result_o keeps its prior value.
- flush_i has priority over start_i.

Signedness:
- MULH: rs1 and rs2 signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MULHU and MUL: both unsigned magnitudes. MUL takes the low 32 bits, which are sign-independent.
- DIV/REM: signed. Quotient is negative iff operand signs differ. Remainder takes the dividend's sign.
- DIVU/REMU: unsigned.

Arithmetic:
- Multiply uses a 64-bit product register. Negation is two's complement over 64 bits before selecting the high or low word.
- Divide uses a 33-bit partial remainder and 32-bit quotient.

Outputs:
- stallreq_o = (IDLE & start_i & ~flush_i & not fast-case-blocked) | CALC.
  - It is deasserted in DONE so execute writes back result_o in that cycle.
  - In IDLE with a fast case, stallreq_o is still 1 for the request cycle.
- Reset values: state IDLE, counter 0, busy_o 0, done_o 0, result_o 0, stallreq_o 0 (start_i low).
- Reset mid-operation is identical to flush, and also clears result_o.

## Timing

- Edge T0: a normal request is accepted.
- Edges T1..T32: CALC iterations; busy_o=1 and stallreq_o=1.
- Edge T32: transition to DONE. done_o=1 during the cycle T32..T33.
- Latency: 33 cycles from accept to done_o. Total stall: 33 cycles including the request cycle.
- Fast case: accepted at T0; done_o during T0..T1 (latency 1).
- result_o holds until the next completed operation or reset.
- Back-to-back requests are possible: a new start_i is accepted in the IDLE cycle after DONE. Minimum spacing between accepts is 34 cycles (normal) or 2 cycles (fast).
- done_o never coincides with stallreq_o=1.

## Test plan

- MUL 7 × 0xFFFFFFFD → result_o 0xFFFFFFEB. done_o is high exactly 33 cycles after accept; stallreq_o is high for 33 cycles, then 0.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU same operands → 0x40000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIVU 100/7 → 14; REMU → 2; DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, with 1-cycle latency. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0, also 1-cycle latency.
- flush_i pulsed in CALC cycle 10 → IDLE next edge, no done_o, result_o unchanged. A new MUL 3×4 requested the following cycle → 12 after 33 cycles.
- rst_i asserted in CALC cycle 20 → all outputs 0 next edge. A simultaneous start_i with rst_i is ignored.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit for the execute stage.
// A multiply uses 32 shift-add steps. A divide uses 32 restoring steps on magnitudes.
// The sign is fixed up once, on the last step. The divide-by-zero and signed-overflow
// cases complete in a single cycle.
module muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            stallreq_o
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic        r_neg;
  logic [31:0] r_mcand;   // multiplicand magnitude, or divisor magnitude
  logic [63:0] r_acc;     // product {hi, multiplier}; for divide the low word is the quotient
  logic [31:0] r_rem;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;

  logic        w_sgn1, w_sgn2, w_neg;
  logic [31:0] w_abs1, w_abs2;
  logic        w_fast;
  logic [31:0] w_fast_res;
  logic [32:0] w_sum;
  logic [63:0] w_mul_nxt;
  logic [32:0] w_shift;
  logic        w_fits;
  logic [31:0] w_rem_nxt, w_quo_nxt;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix, w_rem_fix;
  logic [31:0] w_calc_res;

  // Operand signedness, magnitudes and result sign for the incoming request
  always_comb begin
    w_sgn1 = 1'b0;
    w_sgn2 = 1'b0;
    w_neg  = 1'b0;
    case (op_i)
      OP_MULH:   begin w_sgn1 = 1'b1; w_sgn2 = 1'b1; w_neg = rs1_i[31] ^ rs2_i[31]; end
      OP_MULHSU: begin w_sgn1 = 1'b1; w_neg = rs1_i[31]; end
      OP_DIV:    begin w_sgn1 = 1'b1; w_sgn2 = 1'b1; w_neg = rs1_i[31] ^ rs2_i[31]; end
      OP_REM:    begin w_sgn1 = 1'b1; w_sgn2 = 1'b1; w_neg = rs1_i[31]; end
      default:   begin w_sgn1 = 1'b0; w_sgn2 = 1'b0; w_neg = 1'b0; end
    endcase
    if (w_sgn1 && rs1_i[31]) begin
      w_abs1 = 32'd0 - rs1_i;
    end else begin
      w_abs1 = rs1_i;
    end
    if (w_sgn2 && rs2_i[31]) begin
      w_abs2 = 32'd0 - rs2_i;
    end else begin
      w_abs2 = rs2_i;
    end
  end

  // Single-cycle divide cases: division by zero and the signed overflow
  always_comb begin
    w_fast     = 1'b0;
    w_fast_res = 32'd0;
    if (op_i[2] && (rs2_i == 32'd0)) begin
      w_fast     = 1'b1;
      w_fast_res = op_i[1] ? rs1_i : 32'hFFFF_FFFF;
    end else if (((op_i == OP_DIV) || (op_i == OP_REM)) &&
                 (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF)) begin
      w_fast     = 1'b1;
      w_fast_res = op_i[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      w_fast     = 1'b0;
      w_fast_res = 32'd0;
    end
  end

  // One iteration step, plus the sign-corrected result that is used on the final step
  always_comb begin
    w_sum     = {1'b0, r_acc[63:32]} + {1'b0, r_mcand};
    if (r_acc[0]) begin
      w_mul_nxt = {w_sum, r_acc[31:1]};
    end else begin
      w_mul_nxt = {1'b0, r_acc[63:1]};
    end
    // The 33-bit shifted partial remainder always fits after the subtract succeeds
    w_shift   = {r_rem, r_acc[31]};
    w_fits    = (w_shift >= {1'b0, r_mcand});
    if (w_fits) begin
      w_rem_nxt = w_shift[31:0] - r_mcand;
    end else begin
      w_rem_nxt = w_shift[31:0];
    end
    w_quo_nxt  = {r_acc[30:0], w_fits};
    w_prod_fix = r_neg ? (64'd0 - w_mul_nxt) : w_mul_nxt;
    w_quo_fix  = r_neg ? (32'd0 - w_quo_nxt) : w_quo_nxt;
    w_rem_fix  = r_neg ? (32'd0 - w_rem_nxt) : w_rem_nxt;
    case (r_op)
      OP_MUL:                     w_calc_res = w_prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod_fix[63:32];
      OP_DIV, OP_DIVU:            w_calc_res = w_quo_fix;
      OP_REM, OP_REMU:            w_calc_res = w_rem_fix;
      default:                    w_calc_res = 32'd0;
    endcase
  end

  // Sequencer FSM and datapath registers; flush kills, reset also clears the result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_op     <= 3'd0;
      r_neg    <= 1'b0;
      r_mcand  <= 32'd0;
      r_acc    <= 64'd0;
      r_rem    <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i && w_fast) begin
            r_result <= w_fast_res;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (start_i) begin
            r_op    <= op_i;
            r_neg   <= w_neg;
            r_mcand <= op_i[2] ? w_abs2 : w_abs1;
            r_acc   <= {32'd0, (op_i[2] ? w_abs1 : w_abs2)};
            r_rem   <= 32'd0;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_acc <= r_op[2] ? {32'd0, w_quo_nxt} : w_mul_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST_ITER) begin
            r_result <= w_calc_res;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign result_o   = r_result;
  assign stallreq_o = ~rst_i & (((r_state == S_IDLE) & start_i & ~flush_i) |
                                (r_state == S_CALC));

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq with hand-computed expectations.
module tb_muldiv_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        stallreq_o;

  int n_vec = 0;
  int n_err = 0;

  muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one request for one cycle; returns at the negedge after the accept edge.
  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic req_stall);
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    #1;
    req_stall = stallreq_o;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Runs one operation to completion and checks result, latency and stall length.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic req_stall;
    int   k;
    int   stalls;
    bit   seen;
    accept(op, a, b, req_stall);
    stalls = req_stall ? 1 : 0;
    k      = 0;
    seen   = 1'b0;
    while (!seen && (k < 40)) begin
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (stallreq_o) stalls++;
        k++;
        @(negedge clk_i);
      end
    end
    check({tag, " latency"}, 32'(k), 32'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    check({tag, " stall cycles"}, 32'(stalls), 32'(exp_lat + 1));
    check({tag, " stall at done"}, {31'd0, stallreq_o}, 32'd0);
    @(negedge clk_i);
    check({tag, " done pulse width"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin : stim
    logic req_stall;
    bit   done_seen;
    rst_i   = 1'b1;
    start_i = 1'b0;
    op_i    = 3'd0;
    rs1_i   = 32'd0;
    rs2_i   = 32'd0;
    flush_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset done", {31'd0, done_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset stallreq", {31'd0, stallreq_o}, 32'd0);
    rst_i = 1'b0;

    run_op("MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
    run_op("MULH min*min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32);
    run_op("MULHU 2^31*2^31", 3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32);
    run_op("MULHSU -1*2",     3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 32);

    // Flush during CALC iteration 10: no done, result keeps 0xFFFFFFFF
    accept(3'd0, 32'd5, 32'd6, req_stall);
    check("flush req stall", {31'd0, req_stall}, 32'd1);
    done_seen = 1'b0;
    repeat (10) begin
      if (done_o) done_seen = 1'b1;
      @(negedge clk_i);
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush busy", {31'd0, busy_o}, 32'd0);
    check("flush stallreq", {31'd0, stallreq_o}, 32'd0);
    check("flush no done", {31'd0, (done_o | done_seen)}, 32'd0);
    check("flush result held", result_o, 32'hFFFF_FFFF);
    run_op("MUL 3*4 after flush", 3'd0, 32'd3, 32'd4, 32'd12, 32);

    run_op("DIVU 100/7",      3'd5, 32'd100,        32'd7,         32'd14,        32);
    run_op("REMU 100%7",      3'd7, 32'd100,        32'd7,         32'd2,         32);
    run_op("DIV -7/2",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32);
    run_op("REM -7%2",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32);
    run_op("DIVU max/1",      3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 32);
    run_op("DIV 5/0",         3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
    run_op("REM 5%0",         3'd6, 32'd5,          32'd0,         32'd5,         0);
    run_op("DIV ovf",         3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("REM ovf",         3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
    run_op("DIVU 5/0",        3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
    run_op("REMU 9%0",        3'd7, 32'd9,          32'd0,         32'd9,         0);
    run_op("MULHU 2^16*2^16", 3'd3, 32'h0001_0000,  32'h0001_0000, 32'd1,         32);

    // Reset during CALC iteration 20 with a simultaneous start
    accept(3'd0, 32'h0000_FFFF, 32'h0000_FFFF, req_stall);
    repeat (20) @(negedge clk_i);
    rst_i   = 1'b1;
    start_i = 1'b1;
    op_i    = 3'd0;
    rs1_i   = 32'd3;
    rs2_i   = 32'd4;
    @(negedge clk_i);
    check("midrst busy", {31'd0, busy_o}, 32'd0);
    check("midrst done", {31'd0, done_o}, 32'd0);
    check("midrst result", result_o, 32'd0);
    check("midrst stallreq", {31'd0, stallreq_o}, 32'd0);
    rst_i   = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    check("midrst start ignored", {31'd0, busy_o}, 32'd0);
    check("midrst still no done", {31'd0, done_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
